// File: rtl/adc78h90_responder.sv
// ADC78H90 SPI responder: returns a snapshot of an 8x12-bit sample bank and decodes the channel address.
// Optional: define ADC78H90_RESP_TRISTATE_EN to float miso_o while idle.
module adc78h90_responder #(
    parameter logic [2:0] RESET_CH = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk_i,
    input  logic        cs_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    input  logic [95:0] adc_data,
    output logic [2:0]  addr_o,
    output logic        done_o,
    output logic        abort_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDoneWait} state_e;

    state_e      state_q;
    logic [2:0]  sclk_q;
    logic [2:0]  cs_n_q;
    logic [1:0]  mosi_q;
    logic [15:0] shift_q;
    logic [14:0] din_q;      // bit 15 of the received word is never read
    logic [4:0]  rise_cnt_q;
    logic [3:0]  fall_cnt_q;
    logic [2:0]  addr_q;
    logic        done_q;
    logic        abort_q;

    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_rise;
    logic        cs_fall;
    logic [15:0] din_d;
    logic [15:0] shift_d;

    // Stage 1 and 2 synchronize; stage 2 against stage 3 forms the edge.
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_n_q[1] & ~cs_n_q[2];
    assign cs_fall   = ~cs_n_q[1] & cs_n_q[2];
    assign din_d     = {din_q, mosi_q[1]};
    assign shift_d   = {shift_q[14:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sclk_q     <= 3'b111;
            cs_n_q     <= 3'b111;
            mosi_q     <= 2'b00;
            shift_q    <= 16'h0000;
            din_q      <= 15'h0000;
            rise_cnt_q <= 5'd0;
            fall_cnt_q <= 4'd0;
            addr_q     <= RESET_CH;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_i};
            cs_n_q  <= {cs_n_q[1:0], cs_n_i};
            mosi_q  <= {mosi_q[0], mosi_i};
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q    <= StShift;
                        shift_q    <= {4'b0000, adc_data[12*addr_q +: 12]};
                        din_q      <= 15'h0000;
                        rise_cnt_q <= 5'd0;
                        fall_cnt_q <= 4'd0;
                    end
                end
                StShift: begin
                    // CS wins over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        state_q <= StIdle;
                        abort_q <= 1'b1;
                        shift_q <= 16'h0000;
                    end else begin
                        if (sclk_fall && fall_cnt_q < 4'd15) begin
                            shift_q    <= shift_d;
                            fall_cnt_q <= fall_cnt_q + 4'd1;
                        end
                        if (sclk_rise && rise_cnt_q < 5'd16) begin
                            din_q      <= din_d[14:0];
                            rise_cnt_q <= rise_cnt_q + 5'd1;
                            if (rise_cnt_q == 5'd15) begin
                                state_q <= StDoneWait;
                                addr_q  <= din_d[13:11];
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                StDoneWait: begin
                    if (cs_rise) begin
                        state_q <= StIdle;
                        shift_q <= 16'h0000;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ADC78H90_RESP_TRISTATE_EN
    assign miso_o = (state_q == StIdle) ? 1'bz : shift_q[15];
`else
    assign miso_o = shift_q[15];
`endif
    assign addr_o  = addr_q;
    assign done_o  = done_q;
    assign abort_o = abort_q;

endmodule

// File: tb/tb_adc78h90_responder.sv
// Randomized self-checking bench for adc78h90_responder against a frame-level reference model.
module tb_adc78h90_responder;

    localparam logic [2:0] RESET_CH = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [95:0] adc;
    logic [2:0]  addr;
    logic        done;
    logic        abort;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [2:0] done_addr = 3'd0;
    logic [2:0] exp_addr;
    logic       idle_miso;

    always #5 clk = ~clk;

    adc78h90_responder #(.RESET_CH(RESET_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk_i   (sclk),
        .cs_n_i   (cs_n),
        .mosi_i   (mosi),
        .miso_o   (miso),
        .adc_data (adc),
        .addr_o   (addr),
        .done_o   (done),
        .abort_o  (abort)
    );

    always @(negedge clk) begin
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_addr <= addr;
        end
        if (abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] chan(input logic [95:0] b, input logic [2:0] c);
        return b[12*c +: 12];
    endfunction

    // One initiator frame; SCLK idles low, MOSI changes while SCLK is low, MISO sampled before each rise.
    task automatic run_frame(input logic [15:0] mosi_w, input int ncyc, input int chg_fall,
                             input logic [95:0] new_bank, input bit cs_on_last);
        logic [15:0] word;
        logic [31:0] got;
        logic [31:0] exp;
        int d0, a0, counted;
        bit aborted;
        word    = {4'h0, chan(adc, exp_addr)};
        d0      = done_cnt;
        a0      = abort_cnt;
        got     = 32'h0;
        exp     = 32'h0;
        counted = cs_on_last ? ncyc - 1 : ncyc;
        aborted = counted < 16;
        for (int i = 0; i < ncyc; i++) exp[i] = (i < 16) ? word[15-i] : word[0];

        cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < ncyc; i++) begin
            mosi = (i < 16) ? mosi_w[15-i] : 1'($urandom_range(0, 1));
            wait_clk(8);
            got[i] = miso;
            if (cs_on_last && i == ncyc - 1) begin
                cs_n = 1'b1;
                sclk = 1'b1;
                wait_clk(8);
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                wait_clk(8);
                sclk = 1'b0;
                if (i + 1 == chg_fall) adc = new_bank;
            end
            wait_clk(8);
        end
        cs_n = 1'b1;
        wait_clk(8);

        check_eq("miso_bits", got, exp);
        check_eq("done_pulses", 32'(done_cnt - d0), aborted ? 32'd0 : 32'd1);
        check_eq("abort_pulses", 32'(abort_cnt - a0), aborted ? 32'd1 : 32'd0);
        if (!aborted) begin
            exp_addr = mosi_w[13:11];
            check_eq("addr_at_done", 32'(done_addr), 32'(exp_addr));
        end
        check_eq("addr", 32'(addr), 32'(exp_addr));
        check_eq("idle_miso", 32'(miso), 32'(idle_miso));
    endtask

    initial begin
        logic [95:0] bank2;
        int d0, a0;
`ifdef ADC78H90_RESP_TRISTATE_EN
        idle_miso = 1'bz;
`else
        idle_miso = 1'b0;
`endif
        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        adc  = {$urandom, $urandom, $urandom};
        exp_addr = RESET_CH;
        wait_clk(5);
        check_eq("rst_miso", 32'(miso), 32'(idle_miso));
        check_eq("rst_addr", 32'(addr), 32'(RESET_CH));
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_abort", 32'(abort), 32'd0);
        rst = 1'b0;
        wait_clk(8);

        // Basic frame on the reset channel, then address 5, then the new channel's data.
        adc[12*RESET_CH +: 12] = 12'hABC;
        run_frame(16'h0000, 16, -1, 96'h0, 1'b0);
        run_frame(16'h2800, 16, -1, 96'h0, 1'b0);
        adc[12*5 +: 12] = 12'h5A5;
        run_frame(16'h0000, 16, -1, 96'h0, 1'b0);

        // Snapshot: ch0 changes after fall 4.
        adc[11:0] = 12'h123;
        bank2 = adc;
        bank2[11:0] = 12'hFFF;
        run_frame(16'h1000, 16, 4, bank2, 1'b0);

        run_frame(16'h3800, 8, -1, 96'h0, 1'b0);
        run_frame(16'h3000, 20, -1, 96'h0, 1'b0);
        run_frame(16'h0800, 16, -1, 96'h0, 1'b1);
        run_frame(16'h2000, 17, -1, 96'h0, 1'b1);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        a0 = abort_cnt;
        cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom_range(0, 1));
            wait_clk(8);
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
            wait_clk(8);
        end
        rst = 1'b1;
        #1;
        check_eq("midrst_miso", 32'(miso), 32'(idle_miso));
        check_eq("midrst_addr", 32'(addr), 32'(RESET_CH));
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_abort", 32'(abort), 32'd0);
        cs_n = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("midrst_no_abort", 32'(abort_cnt - a0), 32'd0);
        exp_addr = RESET_CH;
        run_frame(16'($urandom), 16, -1, 96'h0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            adc = {$urandom, $urandom, $urandom};
            run_frame(16'($urandom), int'($urandom_range(1, 20)), -1, 96'h0,
                      $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
